// File: rtl/seg_checker.sv
// Checks a 4-bit add/subtract device by decoding its four seven-segment displays
// and sign flag, comparing them against the operands, and keeping pass/fail tallies.
module seg_checker #(
   parameter bit ACTIVE_LOW = 1'b0,
   parameter int CNT_W      = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       inA,
   input  logic [3:0]       inB,
   input  logic             sel,
   input  logic [6:0]       SevenSegA,
   input  logic [6:0]       SevenSegB,
   input  logic [6:0]       SevenSegTen,
   input  logic [6:0]       SevenSegOne,
   input  logic             signal,
   output logic             out_valid,
   output logic             pass,
   output logic             bad_seg,
   output logic [5:0]       dec_result,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] vec_count
);

   typedef enum logic [2:0] {IDLE, CAPTURE, DECODE, COMPARE, REPORT} state_t;

   localparam logic [6:0] SEG_INV = {7{ACTIVE_LOW}};

   // Returns {illegal, value}; anything outside the legend (including blank) is illegal.
   function automatic logic [4:0] dec_hex(input logic [6:0] seg);
      case (seg)
         7'b0111111: dec_hex = 5'h00;
         7'b0000110: dec_hex = 5'h01;
         7'b1011011: dec_hex = 5'h02;
         7'b1001111: dec_hex = 5'h03;
         7'b1100110: dec_hex = 5'h04;
         7'b1101101: dec_hex = 5'h05;
         7'b1111101: dec_hex = 5'h06;
         7'b0000111: dec_hex = 5'h07;
         7'b1111111: dec_hex = 5'h08;
         7'b1101111: dec_hex = 5'h09;
         7'b1110111: dec_hex = 5'h0A;
         7'b1111100: dec_hex = 5'h0B;
         7'b0111001: dec_hex = 5'h0C;
         7'b1011110: dec_hex = 5'h0D;
         7'b1111001: dec_hex = 5'h0E;
         7'b1110001: dec_hex = 5'h0F;
         default:    dec_hex = 5'h10;
      endcase
   endfunction

   function automatic logic [4:0] dec_dec(input logic [6:0] seg);
      logic [4:0] h;
      h       = dec_hex(seg);
      dec_dec = {h[4] | (h[3:0] > 4'd9), h[3:0]};
   endfunction

   state_t     state, state_next;

   logic [3:0] a_q, b_q;
   logic       sel_q, signal_q;
   logic [6:0] seg_a_q, seg_b_q, seg_ten_q, seg_one_q;

   logic [3:0] dig_a, dig_b, dig_ten, dig_one;
   logic       illegal_q;

   logic [4:0] dec_a, dec_b, dec_ten, dec_one;
   logic [6:0] magnitude;
   logic [4:0] exp_mag;
   logic       exp_sign;
   logic       match;
   logic [5:0] signed_result;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = CAPTURE;
         end
         CAPTURE: state_next = DECODE;
         DECODE:  state_next = COMPARE;
         COMPARE: state_next = REPORT;
         REPORT: begin
            out_valid  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: pipeline data registers carry no reset; they are only consumed behind the state sequence.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         a_q       <= inA;
         b_q       <= inB;
         sel_q     <= sel;
         signal_q  <= signal;
         seg_a_q   <= SevenSegA;
         seg_b_q   <= SevenSegB;
         seg_ten_q <= SevenSegTen;
         seg_one_q <= SevenSegOne;
      end
      if (state == DECODE) begin
         dig_a     <= dec_a[3:0];
         dig_b     <= dec_b[3:0];
         dig_ten   <= dec_ten[3:0];
         dig_one   <= dec_one[3:0];
         illegal_q <= dec_a[4] | dec_b[4] | dec_ten[4] | dec_one[4];
      end
   end

   always_comb begin
      dec_a   = dec_hex(seg_a_q ^ SEG_INV);
      dec_b   = dec_hex(seg_b_q ^ SEG_INV);
      dec_ten = dec_dec(seg_ten_q ^ SEG_INV);
      dec_one = dec_dec(seg_one_q ^ SEG_INV);
   end

   always_comb begin
      exp_sign = 1'b0;
      exp_mag  = {1'b0, a_q} + {1'b0, b_q};
      if (sel_q) begin
         if (a_q < b_q) begin
            exp_sign = 1'b1;
            exp_mag  = {1'b0, b_q - a_q};
         end else begin
            exp_mag  = {1'b0, a_q - b_q};
         end
      end
      magnitude     = {3'b000, dig_ten} * 7'd10 + {3'b000, dig_one};
      signed_result = signal_q ? (6'd0 - magnitude[5:0]) : magnitude[5:0];
      // A negative zero is never a legal display, whatever the operands.
      match = (dig_a == a_q) && (dig_b == b_q) &&
              (magnitude == {2'b00, exp_mag}) && (signal_q == exp_sign) &&
              !illegal_q && !(magnitude == 7'd0 && signal_q);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass       <= 1'b0;
         bad_seg    <= 1'b0;
         dec_result <= '0;
         err_count  <= '0;
         vec_count  <= '0;
      end else if (state == COMPARE) begin
         pass       <= match;
         bad_seg    <= illegal_q;
         dec_result <= signed_result;
         if (vec_count != '1)            vec_count <= vec_count + 1'b1;
         if (!match && err_count != '1)  err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_checker.sv
// Scoreboard bench for seg_checker: directed vectors push expectations, a negedge
// monitor pops and compares them against an active-high and an active-low instance.
module tb_seg_checker;

   localparam int CNT_W = 9;

   localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                          S3 = 7'b1001111, S5 = 7'b1101101,
                          S6 = 7'b1111101, S7 = 7'b0000111, S9 = 7'b1101111,
                          SA = 7'b1110111, SC = 7'b0111001, SF = 7'b1110001,
                          BLANK = 7'b0000000;

   typedef struct {
      int         cyc;
      logic       pass;
      logic       bad;
      logic [5:0] dec;
      logic       chk_dec;
      int         vec;
      int         err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [3:0]       in_a = '0, in_b = '0;
   logic             sel = 1'b0, sig = 1'b0;
   logic [6:0]       seg_a = '0, seg_b = '0, seg_ten = '0, seg_one = '0;

   logic             in_ready_0, out_valid_0, pass_0, bad_0;
   logic [5:0]       dec_0;
   logic [CNT_W-1:0] err_0, vec_0;
   logic             in_ready_1, out_valid_1, pass_1, bad_1;
   logic [5:0]       dec_1;
   logic [CNT_W-1:0] err_1, vec_1;

   exp_t sb_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_pulse = 0;
   int   exp_vec = 0;
   int   exp_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seg_checker #(.ACTIVE_LOW(1'b0), .CNT_W(CNT_W)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_0),
      .inA(in_a), .inB(in_b), .sel(sel),
      .SevenSegA(seg_a), .SevenSegB(seg_b), .SevenSegTen(seg_ten), .SevenSegOne(seg_one),
      .signal(sig), .out_valid(out_valid_0), .pass(pass_0), .bad_seg(bad_0),
      .dec_result(dec_0), .err_count(err_0), .vec_count(vec_0)
   );

   seg_checker #(.ACTIVE_LOW(1'b1), .CNT_W(CNT_W)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
      .inA(in_a), .inB(in_b), .sel(sel),
      .SevenSegA(~seg_a), .SevenSegB(~seg_b), .SevenSegTen(~seg_ten), .SevenSegOne(~seg_one),
      .signal(sig), .out_valid(out_valid_1), .pass(pass_1), .bad_seg(bad_1),
      .dec_result(dec_1), .err_count(err_1), .vec_count(vec_1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (out_valid_0 || out_valid_1)) begin
         n_pulse++;
         if (sb_q.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid_0), 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("latency_cycle", cyc, e.cyc);
            check("out_valid_hi", out_valid_0, 1);
            check("out_valid_lo", out_valid_1, 1);
            check("pass_hi", pass_0, e.pass);
            check("pass_lo", pass_1, e.pass);
            check("bad_seg_hi", bad_0, e.bad);
            check("bad_seg_lo", bad_1, e.bad);
            if (e.chk_dec) begin
               check("dec_result_hi", dec_0, e.dec);
               check("dec_result_lo", dec_1, e.dec);
            end
            check("vec_count", vec_0, e.vec);
            check("err_count", err_0, e.err);
            check("vec_count_lo", vec_1, e.vec);
            check("err_count_lo", err_1, e.err);
         end
      end
   end

   task automatic drive(input logic [3:0] a, b, input logic s,
                        input logic [6:0] sa, sbv, st, so, input logic sg);
      in_a = a; in_b = b; sel = s;
      seg_a = sa; seg_b = sbv; seg_ten = st; seg_one = so; sig = sg;
   endtask

   task automatic push_exp(input int at_cyc, input logic ep, eb,
                           input logic [5:0] ed, input logic cd);
      exp_t e;
      if (exp_vec < (1 << CNT_W) - 1) exp_vec++;
      if (!ep && exp_err < (1 << CNT_W) - 1) exp_err++;
      e.cyc = at_cyc; e.pass = ep; e.bad = eb; e.dec = ed; e.chk_dec = cd;
      e.vec = exp_vec; e.err = exp_err;
      sb_q.push_back(e);
   endtask

   // One vector; junk with in_valid held high while busy must be ignored.
   task automatic send(input logic [3:0] a, b, input logic s,
                       input logic [6:0] sa, sbv, st, so, input logic sg,
                       input logic ep, eb, input logic [5:0] ed, input logic cd);
      @(negedge clk);
      check("in_ready_idle", in_ready_0, 1);
      drive(a, b, s, sa, sbv, st, so, sg);
      in_valid = 1'b1;
      push_exp(cyc + 4, ep, eb, ed, cd);
      @(negedge clk);
      check("in_ready_busy", in_ready_0, 0);
      repeat (4) begin
         drive(4'($urandom), 4'($urandom), 1'($urandom), 7'($urandom), 7'($urandom),
               7'($urandom), 7'($urandom), 1'($urandom));
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int k;
      int pulses_before;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready_0, 1);
      check("rst_out_valid", out_valid_0, 0);
      check("rst_pass", pass_0, 0);
      check("rst_dec", dec_0, 0);
      check("rst_vec", vec_0, 0);
      rst = 1'b0;

      //    A  B   sel segA segB ten  one  sig  pass bad dec        chk
      send(7, 9,   0,  S7,  S9,  S1,  S6,  0,   1,   0,  6'd16,     1);
      send(3, 12,  1,  S3,  SC,  S0,  S9,  1,   1,   0,  6'b110111, 1);
      send(7, 9,   0,  S7,  S9,  S1,  SA,  0,   0,   1,  6'd0,      0);
      send(5, 5,   1,  S5,  S5,  S0,  S0,  1,   0,   0,  6'd0,      1);
      send(5, 5,   1,  S5,  S5,  S0,  S0,  0,   1,   0,  6'd0,      1);
      send(15, 15, 0,  SF,  SF,  S3,  S0,  0,   1,   0,  6'd30,     1);
      send(0, 15,  1,  S0,  SF,  S1,  S5,  1,   1,   0,  6'b110001, 1);
      send(2, 1,   0,  S3,  S1,  S0,  S3,  0,   0,   0,  6'd3,      1);
      send(9, 4,   1,  S9,  7'b1100110, S0, S5, 1, 0, 0, 6'd59,     1);
      send(1, 1,   0,  S1,  S1,  BLANK, S2, 0,  0,   1,  6'd0,      0);
      send(1, 1,   0,  BLANK, S1, S0,  S2,  0,  0,   1,  6'd0,      0);
      send(1, 1,   0,  S1,  S1,  S9,  S9,  0,   0,   0,  6'd35,     1);
      send(6, 2,   0,  S6,  S2,  S0,  S7,  0,   0,   0,  6'd7,      1);

      // Back-to-back: in_valid held for 20 cycles.
      @(negedge clk);
      pulses_before = n_pulse;
      k = cyc;
      drive(7, 9, 0, S7, S9, S1, S6, 0);
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) push_exp(k + 4 + 5 * i, 1, 0, 6'd16, 1);
      repeat (20) @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("stream_pulses", n_pulse - pulses_before, 4);

      // Reset during cycle 2 of a check.
      @(negedge clk);
      drive(7, 9, 0, S7, S9, S1, S6, 0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      pulses_before = n_pulse;
      rst = 1'b1;
      #1;
      check("midrst_in_ready", in_ready_0, 1);
      check("midrst_out_valid", out_valid_0, 0);
      check("midrst_pass", pass_0, 0);
      check("midrst_bad", bad_0, 0);
      check("midrst_dec", dec_0, 0);
      check("midrst_vec", vec_0, 0);
      check("midrst_err", err_0, 0);
      exp_vec = 0;
      exp_err = 0;
      repeat (2) @(negedge clk);
      check("midrst_in_ready_held", in_ready_0, 1);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("midrst_no_pulse", n_pulse - pulses_before, 0);
      check("midrst_vec_after", vec_0, 0);

      send(7, 9, 0, S7, S9, S1, S6, 0, 1, 0, 6'd16, 1);

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
      while (sb_q.size() != 0) begin
         exp_t e;
         e = sb_q.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL missing_out_valid: no strobe seen, expected at cycle %0d", e.cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
